// File: rtl/axi_traffic_gen.sv
// rtl/axi_traffic_gen.sv - AXI burst write / read-verify traffic generator
// Optional macro AXI_TRAFFIC_GEN_LFSR_EN selects a 32-bit LFSR data pattern.
module axi_traffic_gen #(
   parameter int ADDR_WIDTH  = 26,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_LEN   = 8,
   parameter int NUM_BURSTS  = 4,
   parameter int BASE_ADDR   = 0,
   parameter int ADDR_STRIDE = BURST_LEN
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic                  init_end,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [7:0]            awlen,
   output logic                  wvalid,
   input  logic                  wready,
   output logic                  wlast,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic                  bvalid,
   output logic                  bready,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [7:0]            arlen,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic                  rlast,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_cnt
);

   typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

   localparam logic [7:0]            LAST_BEAT  = 8'(BURST_LEN - 1);
   localparam logic [15:0]           LAST_BURST = 16'(NUM_BURSTS - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(ADDR_STRIDE);

   state_t                state, state_nxt;
   logic                  verify_r;
   logic [15:0]           burst_cnt;
   logic [7:0]            beat_cnt;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] pat_data;
   logic [15:0]           err_nxt;
   logic                  accept, last_beat, last_burst, beat_acc, phase_start;
   logic                  burst_step, err_inc;

   assign accept      = (state == IDLE) && start && init_end;
   assign last_beat   = (beat_cnt == LAST_BEAT);
   assign last_burst  = (burst_cnt == LAST_BURST);
   assign beat_acc    = ((state == WDATA) && wready) || ((state == RDATA) && rvalid);
   // Both the first phase of a run and the write-to-read turnaround restart burst/pattern counting
   assign phase_start = accept || ((state == WRESP) && bvalid && last_burst);
   assign burst_step  = !last_burst && (((state == WRESP) && bvalid) ||
                                        ((state == RDATA) && rvalid && last_beat));
   assign err_inc     = (state == RDATA) && rvalid && verify_r &&
                        ((rdata != pat_data) || (rlast != last_beat));
   assign err_nxt     = (err_inc && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;

   assign awaddr = addr_r;
   assign araddr = addr_r;
   assign awlen  = LAST_BEAT;
   assign arlen  = LAST_BEAT;
   assign wlast  = (state == WDATA) && last_beat;
   assign wdata  = (state == WDATA) ? pat_data : '0;

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      done      = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (accept) state_nxt = (mode == 2'b01) ? RADDR : WADDR;
         end
         WADDR: begin
            awvalid = 1'b1;
            if (awready) state_nxt = WDATA;
         end
         WDATA: begin
            wvalid = 1'b1;
            if (wready && last_beat) state_nxt = WRESP;
         end
         WRESP: begin
            bready = 1'b1;
            if (bvalid) state_nxt = !last_burst ? WADDR : (verify_r ? RADDR : DONE);
         end
         RADDR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = RDATA;
         end
         RDATA: begin
            rready = 1'b1;
            if (rvalid && last_beat) state_nxt = last_burst ? DONE : RADDR;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         verify_r  <= 1'b0;
         burst_cnt <= '0;
         beat_cnt  <= '0;
         addr_r    <= '0;
         err_cnt   <= '0;
         pass      <= 1'b0;
      end else begin
         if (accept) begin
            verify_r <= mode[1];
            err_cnt  <= '0;
            pass     <= 1'b0;
         end else begin
            err_cnt <= err_nxt;
         end
         if (phase_start) begin
            burst_cnt <= '0;
            beat_cnt  <= '0;
            addr_r    <= BASE;
         end else begin
            if (beat_acc) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
            if (burst_step) begin
               burst_cnt <= burst_cnt + 16'd1;
               addr_r    <= addr_r + STRIDE;
            end
         end
         // pass is captured on entry to DONE so it is valid alongside the done pulse
         if ((state_nxt == DONE) && (state != DONE)) pass <= (err_nxt == 16'd0);
      end
   end

`ifdef AXI_TRAFFIC_GEN_LFSR_EN
   logic [31:0] lfsr;

   always_ff @(posedge clk) begin
      if (!rstn || phase_start) lfsr <= 32'h1;
      else if (beat_acc)        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
   end

   assign pat_data = DATA_WIDTH'({((DATA_WIDTH + 31) / 32){lfsr}});
`else
   // Running beat count within a phase equals n*BURST_LEN+k for beat k of burst n
   logic [15:0] pat_cnt;

   always_ff @(posedge clk) begin
      if (!rstn || phase_start) pat_cnt <= '0;
      else if (beat_acc)        pat_cnt <= pat_cnt + 16'd1;
   end

   assign pat_data = {(DATA_WIDTH / 16){pat_cnt}};
`endif

endmodule
